// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear controller for a 4-digit BCD counter chain: prescales clk
// into count pulses, resets the chain on clear and halts on a BCD limit.
module stopwatch_ctrl #(
    parameter int DIV   = 50_000_000,
    parameter int DIV_W = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic [15:0] limit,
    input  logic [15:0] count_in,
    output logic        cnt_en,
    output logic        cnt_rst,
    output logic        running,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] PRESC_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] PRESC_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic             cnt_rst_q, cnt_rst_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             hit_s;

    // A zero limit means free-run; a non-BCD limit simply never matches.
    assign hit_s = (limit != 16'h0000) && (count_in == limit);

    // Next-state, prescaler and registered-output logic; clear > stop > start.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        cnt_rst_d = 1'b0;
        if (clear) begin
            state_d   = IDLE;
            presc_d   = PRESC_ZERO;
            cnt_rst_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        presc_d = PRESC_ZERO;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (hit_s) begin
                        state_d = DONE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = PRESC_ZERO;
                    end else begin
                        presc_d = presc_q + PRESC_ONE;
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (start) begin
                        state_d = RUN;
                    end else begin
                        state_d = PAUSE;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                    presc_d = PRESC_ZERO;
                end
            endcase
        end
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            presc_q   <= PRESC_ZERO;
            cnt_rst_q <= 1'b1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            cnt_rst_q <= cnt_rst_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    // Suppressing the pulse on hit/stop/clear keeps the chain exactly on limit.
    assign cnt_en  = (state_q == RUN) && (presc_q == PRESC_LAST) && !hit_s && !stop && !clear;
    assign cnt_rst = cnt_rst_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with DIV=4 driving a behavioural BCD chain.
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] limit = 16'h0000;
    logic [15:0] chain = 16'h0000;
    logic        cnt_en, cnt_rst, running, done;
    logic        chain_load = 1'b0;
    logic [15:0] chain_val = 16'h0000;
    logic        stim_done = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        int          c;
        logic        r;
        logic        d;
        logic        cr;
        logic [15:0] v;
    } st_t;

    st_t st_q[$];
    int  ev_q[$];

    stopwatch_ctrl #(.DIV(4), .DIV_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .limit(limit), .count_in(chain), .cnt_en(cnt_en), .cnt_rst(cnt_rst),
        .running(running), .done(done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] bcd_inc(input logic [15:0] x);
        logic [15:0] y;
        logic        carry;
        y = x;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (y[i*4 +: 4] == 4'd9) begin
                    y[i*4 +: 4] = 4'd0;
                end else begin
                    y[i*4 +: 4] = y[i*4 +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return y;
    endfunction

    // Behavioural counter chain fed by the controller.
    always_ff @(posedge clk) begin
        if (cnt_rst === 1'b1)      chain <= 16'h0000;
        else if (chain_load)       chain <= chain_val;
        else if (cnt_en === 1'b1)  chain <= bcd_inc(chain);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic s, input logic p, input logic c);
        start = s; stop = p; clear = c;
        step(1);
        start = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    task automatic exp_st(input int c, input logic r, input logic d, input logic cr, input logic [15:0] v);
        st_t e;
        e.c = c; e.r = r; e.d = d; e.cr = cr; e.v = v;
        st_q.push_back(e);
    endtask

    task automatic chk(input string name, input int c, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, c, got, want);
        end
    endtask

    // Stimulus: every expectation is pushed before the cycle it refers to.
    initial begin
        int t, c, s;
        step(2);
        exp_st(cyc, 1'b0, 1'b0, 1'b1, 16'h0000);

        // free-run counting from IDLE
        rst = 1'b0;
        t = cyc;
        exp_st(t + 1, 1'b1, 1'b0, 1'b0, 16'h0000);
        ev_q.push_back(t + 4); ev_q.push_back(t + 8); ev_q.push_back(t + 12);
        exp_st(t + 13, 1'b1, 1'b0, 1'b0, 16'h0003);
        pulse(1'b1, 1'b0, 1'b0);
        step(12);
        c = cyc;
        exp_st(c + 1, 1'b0, 1'b0, 1'b1, 16'h0003);
        exp_st(c + 2, 1'b0, 1'b0, 1'b0, 16'h0000);
        pulse(1'b0, 1'b0, 1'b1);
        step(1);

        // limit stop at 0003, then DONE event handling
        limit = 16'h0003;
        t = cyc;
        ev_q.push_back(t + 4); ev_q.push_back(t + 8); ev_q.push_back(t + 12);
        exp_st(t + 13, 1'b1, 1'b0, 1'b0, 16'h0003);
        exp_st(t + 14, 1'b0, 1'b1, 1'b0, 16'h0003);
        exp_st(t + 34, 1'b0, 1'b1, 1'b0, 16'h0003);
        exp_st(t + 35, 1'b0, 1'b1, 1'b0, 16'h0003);
        exp_st(t + 36, 1'b0, 1'b1, 1'b0, 16'h0003);
        exp_st(t + 37, 1'b0, 1'b0, 1'b1, 16'h0003);
        exp_st(t + 38, 1'b0, 1'b0, 1'b0, 16'h0000);
        pulse(1'b1, 1'b0, 1'b0);
        step(33);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b1);
        step(1);

        // pause at presc==2, resume, start+stop in PAUSE, run to 0042, clear
        limit = 16'h0000;
        t = cyc;
        exp_st(t + 1, 1'b1, 1'b0, 1'b0, 16'h0000);
        exp_st(t + 4, 1'b0, 1'b0, 1'b0, 16'h0000);
        exp_st(t + 14, 1'b0, 1'b0, 1'b0, 16'h0000);
        s = t + 14;
        exp_st(s + 1, 1'b1, 1'b0, 1'b0, 16'h0000);
        ev_q.push_back(s + 2);
        exp_st(s + 3, 1'b1, 1'b0, 1'b0, 16'h0001);
        exp_st(s + 4, 1'b0, 1'b0, 1'b0, 16'h0001);
        exp_st(s + 5, 1'b0, 1'b0, 1'b0, 16'h0001);
        for (int k = 0; k < 41; k++) ev_q.push_back(s + 9 + 4 * k);
        exp_st(s + 170, 1'b1, 1'b0, 1'b0, 16'h0042);
        exp_st(s + 171, 1'b0, 1'b0, 1'b1, 16'h0042);
        exp_st(s + 172, 1'b0, 1'b0, 1'b0, 16'h0000);
        pulse(1'b1, 1'b0, 1'b0);
        step(2);
        pulse(1'b0, 1'b1, 1'b0);
        step(10);
        pulse(1'b1, 1'b0, 1'b0);
        step(2);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        step(164);
        pulse(1'b0, 1'b0, 1'b1);
        step(1);

        // 9999 wrap in free-run, then reset mid-RUN
        chain_val = 16'h9997;
        chain_load = 1'b1;
        step(1);
        chain_load = 1'b0;
        t = cyc;
        exp_st(t + 1, 1'b1, 1'b0, 1'b0, 16'h9997);
        ev_q.push_back(t + 4); ev_q.push_back(t + 8);
        ev_q.push_back(t + 12); ev_q.push_back(t + 16);
        exp_st(t + 9, 1'b1, 1'b0, 1'b0, 16'h9999);
        exp_st(t + 13, 1'b1, 1'b0, 1'b0, 16'h0000);
        exp_st(t + 18, 1'b0, 1'b0, 1'b1, 16'h0001);
        exp_st(t + 19, 1'b0, 1'b0, 1'b1, 16'h0000);
        exp_st(t + 20, 1'b0, 1'b0, 1'b0, 16'h0000);
        pulse(1'b1, 1'b0, 1'b0);
        step(16);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(3);
        stim_done = 1'b1;
    end

    // Monitor: pops expectations as the DUT reaches each cycle or pulses cnt_en.
    initial begin
        st_t e;
        forever begin
            @(negedge clk);
            if (cnt_en === 1'b1) begin
                total++;
                if (ev_q.size() > 0 && ev_q[0] == cyc) begin
                    void'(ev_q.pop_front());
                end else begin
                    bad++;
                    $display("FAIL cnt_en_unexpected cyc=%0d got=1 want=0", cyc);
                end
            end
            while (ev_q.size() > 0 && ev_q[0] < cyc) begin
                total++;
                bad++;
                $display("FAIL cnt_en_missing cyc=%0d got=0 want=1", ev_q[0]);
                void'(ev_q.pop_front());
            end
            while (st_q.size() > 0 && st_q[0].c <= cyc) begin
                e = st_q.pop_front();
                if (e.c < cyc) begin
                    total++;
                    bad++;
                    $display("FAIL status_skipped cyc=%0d got=late want=checked", e.c);
                end else begin
                    chk("running", cyc, {15'd0, running}, {15'd0, e.r});
                    chk("done", cyc, {15'd0, done}, {15'd0, e.d});
                    chk("cnt_rst", cyc, {15'd0, cnt_rst}, {15'd0, e.cr});
                    chk("count_in", cyc, chain, e.v);
                end
            end
            if (stim_done) begin
                chk("pending_pulses", cyc, 16'(ev_q.size()), 16'h0000);
                chk("pending_status", cyc, 16'(st_q.size()), 16'h0000);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            if (cyc > 5000) begin
                $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
                $fatal(1);
            end
        end
    end

endmodule
